tick_divider_bank: RTL and testbench
====================================

# tick_divider_bank

Multi-channel programmable tick generator, the parametrised successor to the fixed 1 Hz divider. It produces, per channel, a one-cycle tick every D clock cycles and a square wave of period 2·D. The divisor D is programmable at run time per channel through a write port, with glitch-free update at the channel's wrap. It sits between the board clock and the PWM, blink and scan-rate blocks, replacing a separate fixed divider per consumer.

## Interface
Parameters:
- WIDTH, 24: counter and divisor width in bits.
- CHANNELS, 4: number of independent channels, 1..16.
- DEFAULT_DIV, 12000000: divisor loaded into every channel at reset. Must be < 2^WIDTH.
- CW, max(1, clog2(CHANNELS)): width of the channel select (derived).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global count enable; low freezes all channels.
- sync_clear  in  1  synchronous restart of all channels, for phase alignment.
- wr_en  in  1  divisor write strobe, one cycle per write.
- wr_chan  in  CW  channel addressed by the write.
- wr_div  in  WIDTH  new divisor D for that channel.
- tick  out  CHANNELS  per-channel one-cycle pulse, registered.
- wave  out  CHANNELS  per-channel square wave, toggles on each tick, registered.
- busy  out  CHANNELS  per-channel flag: a written divisor is pending and not yet active.

## Operation
- Per-channel state:
  - count[WIDTH]
  - active[WIDTH], the divisor in use
  - pending[WIDTH]
  - pend_valid
- Reset (reset=0, asynchronous):
  - count=0, active=pending=DEFAULT_DIV, pend_valid=0.
  - tick=0, wave=0, busy=0.
- Counting, for a channel with active=D≥1 and enable=1:
  - If count==D-1: count←0, tick←1, wave←~wave (wrap).
  - Otherwise: count←count+1, tick←0.
- Divisor D=0 disables the channel:
  - count held at 0, tick=0, wave holds its value.
  - A pending divisor is taken at the next enabled edge.
- D=1 gives tick=1 on every enabled cycle and wave toggling every cycle.
- enable=0:
  - count, wave and active hold, tick=0.
  - Writes are still accepted into pending.
- Write (wr_en=1):
  - pending[wr_chan]←wr_div, pend_valid←1.
  - A write to wr_chan ≥ CHANNELS is ignored.
  - A second write before the first is applied overwrites pending; last write wins.
- Apply: on the edge where a channel wraps, or where it is disabled (D=0), and pend_valid=1:
  - active←pending, pend_valid←0.
  - The new D governs the following period.
- Active D never changes mid-period, so there are no runt ticks.
- sync_clear=1 (takes priority over counting; applies even when enable=0):
  - All count←0, tick←0, wave←0.
  - Every channel with pend_valid applies pending immediately.
- sync_clear and wr_en on the same edge: the write lands in pending after the clear, so it is applied at the next wrap, not immediately.
- busy = pend_valid, registered.

## Timing
- After reset release or sync_clear, with enable held high, tick first rises after the D-th rising edge. Ticks then repeat every D cycles, each one cycle wide.
- wave period is 2·D cycles, high for D cycles; its first rising edge coincides with the first tick.
- busy rises on the edge after wr_en. It falls on the edge of the wrap that applies the divisor; tick is high in that same cycle.
- Write-to-effect latency is variable: up to one full old period, plus the new period.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, CHANNELS=4, DEFAULT_DIV=5; release reset with enable=1 -> every tick pulses on cycles 5, 10, 15; wave is high for cycles 5–9 and low for 10–14; busy=0 throughout.
- Write D=3 to channel 2 at cycle 7 -> busy[2]=1 from cycle 8; tick[2] still fires at 10 and busy[2] clears there; then ticks at 13, 16; other channels unchanged.
- Write D=0 to channel 1, then D=1 after it is applied -> tick[1] stays 0 while disabled; after the second write, tick[1]=1 on every cycle and wave[1] toggles every cycle.
- enable=0 for 4 cycles mid-period -> no ticks, counts frozen, all subsequent ticks delayed by exactly 4 cycles; a write issued during the freeze is held with busy=1.
- Channels at D=3, 4, 5, then sync_clear pulsed with a pending write on channel 0 -> all counts and waves are 0, channel 0 takes the pending D at once, and all channels tick simultaneously 60 cycles later (LCM of 3, 4 and 5 with no further writes).
- Assert reset mid-period and mid-pending -> outputs go to 0 asynchronously, before the next clock edge; after release, all channels run at D=5 and pending is discarded.

Source files
------------

// File: rtl/tick_divider_bank.sv
// tick_divider_bank: per-channel programmable tick and square-wave generator.
// Divisors are reprogrammed at run time and only take effect at a wrap.
module tick_divider_bank #(
  parameter int WIDTH       = 24,
  parameter int CHANNELS    = 4,
  parameter int DEFAULT_DIV = 12000000,
  parameter int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync_clear,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [WIDTH-1:0]    wr_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] busy
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] pend;
    logic             pv;
    logic             t;
    logic             w;
    logic             sel;
    logic             idle;
    logic             wrap;
    logic             take;

    assign sel  = wr_en && (int'(wr_chan) == g);
    assign idle = (act == '0);
    assign wrap = !idle && (cnt == act - WIDTH'(1));
    assign take = pv && (sync_clear || (enable && (idle || wrap)));

    // Channel counter, divisor swap at wrap, and pending-write bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt  <= '0;
        act  <= DEF;
        pend <= DEF;
        pv   <= 1'b0;
        t    <= 1'b0;
        w    <= 1'b0;
      end else begin
        if (take) act <= pend;
        if (sel) begin
          pend <= wr_div;
          pv   <= 1'b1;
        end else if (take) begin
          pv <= 1'b0;
        end
        if (sync_clear) begin
          cnt <= '0;
          t   <= 1'b0;
          w   <= 1'b0;
        end else if (enable && !idle) begin
          t   <= wrap;
          cnt <= wrap ? '0 : cnt + WIDTH'(1);
          if (wrap) w <= ~w;
        end else begin
          t <= 1'b0;
        end
      end
    end

    assign tick[g] = t;
    assign wave[g] = w;
    assign busy[g] = pv;
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// tb_tick_divider_bank: table vectors plus a countdown reference model
// whose per-cycle predictions are queued and compared after each edge.
module tb_tick_divider_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sync_clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [7:0] wr_div = '0;
  logic [3:0] tick;
  logic [3:0] wave;
  logic [3:0] busy;

  int n_tests = 0;
  int n_fail = 0;

  tick_divider_bank #(
    .WIDTH(8),
    .CHANNELS(4),
    .DEFAULT_DIV(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sync_clear(sync_clear),
    .wr_en(wr_en),
    .wr_chan(wr_chan),
    .wr_div(wr_div),
    .tick(tick),
    .wave(wave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [11:0] sb[$];

  int m_act[4];
  int m_pend[4];
  int m_left[4];
  bit m_pv[4];
  bit m_tick[4];
  bit m_wave[4];

  task automatic check(string nm, logic [11:0] got, logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 5; m_pend[i] = 5; m_left[i] = 5;
      m_pv[i] = 0; m_tick[i] = 0; m_wave[i] = 0;
    end
  endtask

  // Countdown model: m_left is the number of enabled edges to the next tick.
  task automatic model_edge(bit en, bit sc, bit we, logic [1:0] ch, int div);
    for (int i = 0; i < 4; i++) begin
      bit nt;
      nt = 0;
      if (sc) begin
        if (m_pv[i]) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
        m_left[i] = m_act[i];
        m_wave[i] = 0;
      end else if (en) begin
        if (m_act[i] == 0) begin
          if (m_pv[i]) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
          m_left[i] = m_act[i];
        end else begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            nt = 1;
            m_wave[i] = !m_wave[i];
            if (m_pv[i]) begin m_act[i] = m_pend[i]; m_pv[i] = 0; end
            m_left[i] = m_act[i];
          end
        end
      end
      m_tick[i] = nt;
      if (we && int'(ch) == i) begin m_pend[i] = div; m_pv[i] = 1; end
    end
  endtask

  function automatic logic [11:0] model_obs();
    logic [11:0] o;
    for (int i = 0; i < 4; i++) begin
      o[8+i] = m_tick[i];
      o[4+i] = m_wave[i];
      o[i]   = m_pv[i];
    end
    return o;
  endfunction

  task automatic step(bit en, bit sc, bit we, logic [1:0] ch, logic [7:0] div);
    @(negedge clk);
    enable = en; sync_clear = sc; wr_en = we; wr_chan = ch; wr_div = div;
    model_edge(en, sc, we, ch, int'(div));
    sb.push_back(model_obs());
    @(posedge clk);
    #1;
    check("model", {tick, wave, busy}, sb.pop_front());
  endtask

  task automatic run(int n, bit en);
    for (int i = 0; i < n; i++) step(en, 0, 0, 2'd0, 8'd0);
  endtask

  typedef struct {
    bit         we;
    logic [1:0] ch;
    logic [7:0] div;
    logic [3:0] t;
    logic [3:0] w;
    logic [3:0] b;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int k;
    int gap;
    int ones;
    int tog;
    int first;
    logic pw;

    for (int i = 0; i < 16; i++) tbl[i] = '{0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0};
    tbl[5]  = '{0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0};
    tbl[6]  = '{0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h0};
    tbl[7]  = '{1, 2'd2, 8'd3, 4'h0, 4'hF, 4'h4};
    tbl[8]  = '{0, 2'd0, 8'd0, 4'h0, 4'hF, 4'h4};
    tbl[9]  = '{0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0};
    tbl[12] = '{0, 2'd0, 8'd0, 4'h4, 4'h4, 4'h0};
    tbl[13] = '{0, 2'd0, 8'd0, 4'h0, 4'h4, 4'h0};
    tbl[14] = '{0, 2'd0, 8'd0, 4'hB, 4'hF, 4'h0};
    tbl[15] = '{0, 2'd0, 8'd0, 4'h4, 4'hB, 4'h0};

    #1 reset = 1'b0;
    #2 check("reset_state", {tick, wave, busy}, 12'h000);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(1, 0, tbl[i].we, tbl[i].ch, tbl[i].div);
      check($sformatf("table[%0d]", i + 1), {tick, wave, busy},
            {tbl[i].t, tbl[i].w, tbl[i].b});
    end

    step(1, 0, 1, 2'd1, 8'd0);
    run(12, 1);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 2'd0, 8'd0);
      ones += int'(tick[1]);
    end
    check("d0_no_tick", 12'(ones), 12'd0);

    step(1, 0, 1, 2'd1, 8'd1);
    run(2, 1);
    ones = 0;
    tog = 0;
    pw = wave[1];
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 2'd0, 8'd0);
      ones += int'(tick[1]);
      if (wave[1] != pw) tog++;
      pw = wave[1];
    end
    check("d1_ticks", 12'(ones), 12'd6);
    check("d1_toggles", 12'(tog), 12'd6);

    k = 0;
    do begin step(1, 0, 0, 2'd0, 8'd0); k++; end while (!tick[0] && k < 20);
    run(2, 1);
    step(0, 0, 0, 2'd0, 8'd0);
    step(0, 0, 1, 2'd3, 8'd5);
    step(0, 0, 0, 2'd0, 8'd0);
    step(0, 0, 0, 2'd0, 8'd0);
    check("freeze_busy", {11'd0, busy[3]}, 12'd1);
    gap = 6;
    k = 0;
    do begin step(1, 0, 0, 2'd0, 8'd0); gap++; k++; end
    while (!tick[0] && k < 20);
    check("freeze_gap", 12'(gap), 12'd9);

    step(1, 0, 1, 2'd1, 8'd4);
    run(10, 1);
    step(1, 0, 1, 2'd0, 8'd3);
    step(1, 1, 0, 2'd0, 8'd0);
    check("sync_clear", {tick, wave, busy}, 12'h000);
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 2'd0, 8'd0);
      if (first == 0 && tick == 4'hF) first = i;
    end
    check("lcm_align", 12'(first), 12'd60);

    step(1, 1, 1, 2'd2, 8'd4);
    check("sc_wr_busy", {8'd0, busy}, 12'h004);
    run(2, 1);
    step(1, 0, 0, 2'd0, 8'd0);
    check("sc_wr_apply", {10'd0, tick[2], busy[2]}, 12'b10);

    step(1, 0, 1, 2'd1, 8'd7);
    run(2, 1);
    #2 reset = 1'b0;
    #1 check("async_reset", {tick, wave, busy}, 12'h000);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    run(4, 1);
    step(1, 0, 0, 2'd0, 8'd0);
    check("post_reset", {tick, busy}, 8'hF0);
    run(5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
